// File: rtl/stream_merge_arbiter_if.sv
// Shared clock-descriptor type and the generic valid/ready stream interface
// used by stream_merge_arbiter.
package std_types_pkg;
  typedef logic [7:0] std_clock_info_t;
endpackage

interface std_stream_intf #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] payload;

  modport in  (input valid, input payload, output ready);
  modport out (output valid, output payload, input ready);
endinterface

// File: rtl/stream_merge_arbiter.sv
// Round-robin merge of PORTS valid/ready streams into one registered output tagged
// with the source index. Define STREAM_MERGE_ARBITER_PACKET_LOCK_EN to keep a port's packet contiguous.
module stream_merge_arbiter
  import std_types_pkg::*;
#(
  parameter std_clock_info_t CLOCK_INFO = 'b0,
  parameter int              PORTS      = 2,
  parameter int              ID_WIDTH   = $clog2(PORTS),
  parameter int              DATA_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  std_stream_intf.in          stream_in [PORTS],
  input  logic [PORTS-1:0]    stream_in_last,
  std_stream_intf.out         stream_out,
  output logic [ID_WIDTH-1:0] stream_out_id
);

  localparam std_clock_info_t unused_clock_info = CLOCK_INFO;

  if (PORTS < 2) begin : g_ports_check
    $error("stream_merge_arbiter: PORTS must be greater than 1");
  end

  logic [PORTS-1:0]      in_valid;
  logic [PORTS-1:0]      in_ready;
  logic [DATA_WIDTH-1:0] in_payload [PORTS];

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] payload_q, payload_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;

  logic                  buf_free;
  logic                  accept;
  logic                  rr_grant_valid;
  logic [ID_WIDTH-1:0]   rr_grant_idx;
  logic                  grant_valid;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic                  hold_ptr;
  logic [ID_WIDTH-1:0]   next_after_grant;

  for (genvar k = 0; k < PORTS; k++) begin : g_port
    assign in_valid[k]        = stream_in[k].valid;
    assign in_payload[k]      = stream_in[k].payload;
    assign stream_in[k].ready = in_ready[k];

    always_ff @(posedge clk) begin
      if (!rst) begin
        assert ($bits(stream_in[k].payload) == $bits(stream_out.payload))
          else $error("stream_merge_arbiter: stream_in[%0d] payload width differs from stream_out", k);
      end
    end
  end

  // Later scan positions are overwritten by earlier ones, so the port closest to rr_ptr wins.
  always_comb begin
    int idx;
    idx            = 0;
    rr_grant_valid = 1'b0;
    rr_grant_idx   = '0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= PORTS) idx = idx - PORTS;
      if (in_valid[ID_WIDTH'(idx)]) begin
        rr_grant_valid = 1'b1;
        rr_grant_idx   = ID_WIDTH'(idx);
      end
    end
  end

`ifdef STREAM_MERGE_ARBITER_PACKET_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_state_e;

  lock_state_e         state_q, state_d;
  logic [ID_WIDTH-1:0] lock_port_q, lock_port_d;
  logic                locked;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lock_port_q <= '0;
    end else begin
      state_q     <= state_d;
      lock_port_q <= lock_port_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_port_d = lock_port_q;
    case (state_q)
      IDLE: begin
        if (accept && !stream_in_last[grant_idx]) begin
          state_d     = LOCKED;
          lock_port_d = grant_idx;
        end
      end
      LOCKED: begin
        if (accept && stream_in_last[grant_idx]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // While locked only the owning port competes; the pointer moves only on a last beat.
  always_comb begin
    locked      = (state_q == LOCKED);
    grant_valid = locked ? in_valid[lock_port_q] : rr_grant_valid;
    grant_idx   = locked ? lock_port_q : rr_grant_idx;
    hold_ptr    = !stream_in_last[grant_idx];
  end
`else
  logic unused_last;
  assign unused_last = ^stream_in_last;

  always_comb begin
    grant_valid = rr_grant_valid;
    grant_idx   = rr_grant_idx;
    hold_ptr    = 1'b0;
  end
`endif

  assign buf_free = !valid_q || stream_out.ready;
  assign accept   = !rst && buf_free && grant_valid;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[grant_idx] = 1'b1;
  end

  assign next_after_grant = (grant_idx == ID_WIDTH'(PORTS - 1)) ? '0
                                                                 : grant_idx + ID_WIDTH'(1);

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    id_d      = id_q;
    rr_ptr_d  = rr_ptr_q;
    if (buf_free) begin
      valid_d = accept;
      if (accept) begin
        payload_d = in_payload[grant_idx];
        id_d      = grant_idx;
      end
    end
    if (accept && !hold_ptr) rr_ptr_d = next_after_grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      id_q      <= '0;
      rr_ptr_q  <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      id_q      <= id_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign stream_out.valid   = valid_q;
  assign stream_out.payload = payload_q;
  assign stream_out_id      = id_q;

endmodule

// File: tb/tb_stream_merge_arbiter.sv
// Directed bench for stream_merge_arbiter with a 4-port and a 3-port instance;
// packet-lock expectations follow STREAM_MERGE_ARBITER_PACKET_LOCK_EN.
module tb_stream_merge_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic [3:0] v4, l4, r4;
  logic [7:0] p4 [4];
  logic       ov4, ordy4;
  logic [7:0] op4;
  logic [1:0] oid4;

  logic [2:0] v3, l3, r3;
  logic [7:0] p3 [3];
  logic       ov3, ordy3;
  logic [7:0] op3;
  logic [1:0] oid3;

  std_stream_intf #(.W(8)) in4 [4] ();
  std_stream_intf #(.W(8)) out4 ();
  std_stream_intf #(.W(8)) in3 [3] ();
  std_stream_intf #(.W(8)) out3 ();

  for (genvar g = 0; g < 4; g++) begin : g_in4
    assign in4[g].valid   = v4[g];
    assign in4[g].payload = p4[g];
    assign r4[g]          = in4[g].ready;
  end

  for (genvar g = 0; g < 3; g++) begin : g_in3
    assign in3[g].valid   = v3[g];
    assign in3[g].payload = p3[g];
    assign r3[g]          = in3[g].ready;
  end

  assign ov4        = out4.valid;
  assign op4        = out4.payload;
  assign out4.ready = ordy4;
  assign ov3        = out3.valid;
  assign op3        = out3.payload;
  assign out3.ready = ordy3;

  stream_merge_arbiter #(.PORTS(4), .DATA_WIDTH(8)) dut4 (
    .clk           (clk),
    .rst           (rst),
    .stream_in     (in4),
    .stream_in_last(l4),
    .stream_out    (out4),
    .stream_out_id (oid4)
  );

  stream_merge_arbiter #(.PORTS(3), .DATA_WIDTH(8)) dut3 (
    .clk           (clk),
    .rst           (rst),
    .stream_in     (in3),
    .stream_in_last(l3),
    .stream_out    (out3),
    .stream_out_id (oid3)
  );

  int assertCount = 0;
  int failCount   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid4, input logic [3:0] last4, input logic ready4);
    v4    = valid4;
    l4    = last4;
    ordy4 = ready4;
  endtask

  int  expId   [5];
  int  expPay  [5];
  int  expVal  [5];
  int  stallId [5];
  int  stallPay[5];
  int  stallVal[5];
  int  stallP0V[5];
  int  stallP0D[5];
  int  stallP0L[5];
  int  bpIds   [3];
  int  bpRdy   [3];
  int  b0;
  logic accepted0;

  initial begin
`ifdef STREAM_MERGE_ARBITER_PACKET_LOCK_EN
    expId    = '{0, 0, 0, 1, 1};
    expPay   = '{'hA0, 'hA1, 'hA2, 'h55, 'h55};
    stallVal = '{1, 0, 0, 1, 1};
    stallId  = '{0, 0, 0, 0, 1};
    stallPay = '{'hB0, 0, 0, 'hB1, 'h66};
`else
    expId    = '{0, 1, 0, 1, 0};
    expPay   = '{'hA0, 'h55, 'hA1, 'h55, 'hA2};
    stallVal = '{1, 1, 1, 1, 1};
    stallId  = '{0, 1, 1, 0, 1};
    stallPay = '{'hB0, 'h66, 'h66, 'hB1, 'h66};
`endif
    expVal   = '{1, 1, 1, 1, 1};
    stallP0V = '{1, 0, 0, 1, 0};
    stallP0D = '{'hB0, 0, 0, 'hB1, 0};
    stallP0L = '{0, 0, 0, 1, 0};
    bpIds    = '{3, 0, 1};
    bpRdy    = '{'b0001, 'b0010, 'b1000};

    rst = 1'b1;
    applyStimulus(4'b0000, 4'b1111, 1'b1);
    v3 = '0; l3 = 3'b111; ordy3 = 1'b1;
    for (int k = 0; k < 4; k++) p4[k] = 8'h10 + 8'(k);
    for (int k = 0; k < 3; k++) p3[k] = 8'h00;
    tick();
    tick();

    // Reset state, with requests present so gated readys are visible.
    v4 = 4'b1111;
    v3 = 3'b111;
    #1;
    checkOutput("reset_ready4", 32'(r4), 32'h0);
    checkOutput("reset_ready3", 32'(r3), 32'h0);
    checkOutput("reset_valid4", 32'(ov4), 32'h0);
    checkOutput("reset_id4", 32'(oid4), 32'h0);
    checkOutput("reset_payload4", 32'(op4), 32'h0);
    checkOutput("reset_valid3", 32'(ov3), 32'h0);

    // Fairness: all four ports valid, output always ready.
    v3  = '0;
    rst = 1'b0;
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    #1;
    checkOutput("rr_first_ready", 32'(r4), 32'h1);
    checkOutput("rr_no_early_valid", 32'(ov4), 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("rr_valid_%0d", i), 32'(ov4), 32'h1);
      checkOutput($sformatf("rr_id_%0d", i), 32'(oid4), 32'(i % 4));
      checkOutput($sformatf("rr_payload_%0d", i), 32'(op4), 32'h10 + 32'(i % 4));
      checkOutput($sformatf("rr_ready_%0d", i), 32'(r4), 32'(1 << ((i + 1) % 4)));
    end

    // Backpressure with ports 0,1,3 waiting; pointer sits at 2.
    applyStimulus(4'b1011, 4'b1111, 1'b0);
    #1;
    checkOutput("bp_ready_initial", 32'(r4), 32'h0);
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput($sformatf("bp_valid_%0d", c), 32'(ov4), 32'h1);
      checkOutput($sformatf("bp_id_%0d", c), 32'(oid4), 32'h1);
      checkOutput($sformatf("bp_payload_%0d", c), 32'(op4), 32'h11);
      checkOutput($sformatf("bp_ready_%0d", c), 32'(r4), 32'h0);
    end
    ordy4 = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(r4), 32'h8);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("bp_resume_id_%0d", c), 32'(oid4), 32'(bpIds[c]));
      checkOutput($sformatf("bp_resume_ready_%0d", c), 32'(r4), 32'(bpRdy[c]));
    end

    // Reset while a beat is buffered and ports 1,2 request.
    applyStimulus(4'b0110, 4'b1111, 1'b1);
    rst = 1'b1;
    tick();
    checkOutput("midrst_valid", 32'(ov4), 32'h0);
    checkOutput("midrst_id", 32'(oid4), 32'h0);
    checkOutput("midrst_payload", 32'(op4), 32'h0);
    checkOutput("midrst_ready", 32'(r4), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("midrst_first_ready", 32'(r4), 32'h2);
    tick();
    checkOutput("midrst_first_id", 32'(oid4), 32'h1);
    checkOutput("midrst_first_valid", 32'(ov4), 32'h1);

    // Three-beat packet on port 0 against a continuously valid port 1.
    applyStimulus(4'b0000, 4'b1111, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    b0 = 0;
    p4[1] = 8'h55;
    p4[0] = 8'hA0;
    applyStimulus(4'b0011, 4'b1110, 1'b1);
    for (int c = 0; c < 5; c++) begin
      #1;
      accepted0 = r4[0] & v4[0];
      tick();
      checkOutput($sformatf("pkt_valid_%0d", c), 32'(ov4), 32'(expVal[c]));
      checkOutput($sformatf("pkt_id_%0d", c), 32'(oid4), 32'(expId[c]));
      checkOutput($sformatf("pkt_payload_%0d", c), 32'(op4), 32'(expPay[c]));
      if (accepted0) b0++;
      v4[0] = (b0 < 3);
      p4[0] = 8'hA0 + 8'(b0);
      l4[0] = (b0 == 2);
    end

    // Port 0 pauses for two cycles in the middle of its packet.
    applyStimulus(4'b0000, 4'b1111, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    p4[1] = 8'h66;
    for (int c = 0; c < 5; c++) begin
      v4    = {2'b00, 1'b1, stallP0V[c] != 0};
      l4    = {3'b111, stallP0L[c] != 0};
      p4[0] = 8'(stallP0D[c]);
      tick();
      checkOutput($sformatf("stall_valid_%0d", c), 32'(ov4), 32'(stallVal[c]));
      if (stallVal[c] != 0) begin
        checkOutput($sformatf("stall_id_%0d", c), 32'(oid4), 32'(stallId[c]));
        checkOutput($sformatf("stall_payload_%0d", c), 32'(op4), 32'(stallPay[c]));
      end
    end
    applyStimulus(4'b0000, 4'b1111, 1'b1);

    // Three-port instance: pointer wrap from 2 back to 0.
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    v3    = 3'b100;
    p3[2] = 8'hAA;
    #1;
    checkOutput("p3_ready_a", 32'(r3), 32'h4);
    tick();
    checkOutput("p3_valid_a", 32'(ov3), 32'h1);
    checkOutput("p3_id_a", 32'(oid3), 32'h2);
    checkOutput("p3_payload_a", 32'(op3), 32'hAA);
    checkOutput("p3_ready_b", 32'(r3), 32'h4);
    p3[2] = 8'hBB;
    tick();
    checkOutput("p3_valid_b", 32'(ov3), 32'h1);
    checkOutput("p3_id_b", 32'(oid3), 32'h2);
    checkOutput("p3_payload_b", 32'(op3), 32'hBB);
    v3    = 3'b001;
    p3[0] = 8'hCC;
    #1;
    checkOutput("p3_ready_c", 32'(r3), 32'h1);
    tick();
    checkOutput("p3_valid_c", 32'(ov3), 32'h1);
    checkOutput("p3_id_c", 32'(oid3), 32'h0);
    checkOutput("p3_payload_c", 32'(op3), 32'hCC);
    v3 = 3'b111;
    for (int k = 0; k < 3; k++) p3[k] = 8'h30 + 8'(k);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("p3_rot_id_%0d", c), 32'(oid3), 32'((c + 1) % 3));
      checkOutput($sformatf("p3_rot_payload_%0d", c), 32'(op3), 32'h30 + 32'((c + 1) % 3));
    end
    v3 = '0;
    tick();
    checkOutput("p3_drain_valid", 32'(ov3), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
